// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the elastic pipeline stage registers.
//   - ALU opcodes used by instantiating stages to build their NOP_WORD
//   - legal DEPTH range and a helper to check it at elaboration
//   - default width of the optional performance counters
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    // ALU opcode field values that mean "do nothing". A stage builds its
    // NOP_WORD by placing one of these in its opcode field, so a bubble can
    // never be mistaken for real work downstream.
    localparam logic [7:0] ALU_OP_NOP   = 8'h00;
    localparam logic [7:0] ALU_OP_FLUSH = 8'h01;

    // Only a plain register (1) or a two-entry skid buffer (2) is supported.
    localparam int PIPE_DEPTH_MIN = 1;
    localparam int PIPE_DEPTH_MAX = 2;

    localparam int PIPE_CNT_W_DEFAULT = 32;

    function automatic bit pipe_depth_legal(input int depth);
        return (depth >= PIPE_DEPTH_MIN) && (depth <= PIPE_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/pipe_stage_buf_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// Three saturating event counters describing how a pipeline stage is used.
// Only instantiated when PIPE_PERF_CNT_EN is defined.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears counters)
//   rdy             global enable; counters only advance when high
//   out_valid       stage presents a beat downstream
//   out_ready       downstream accepts
//   flush           stage flush request
//   occupied        stage holds at least one beat
//   stall_cnt       cycles with out_valid & !out_ready
//   bubble_cnt      cycles with !out_valid
//   flush_cnt       flush cycles that actually discarded held beats
// -----------------------------------------------------------------------------
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    input  logic             occupied,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

    // Each counter sticks at all-ones instead of wrapping, so a long run
    // reads as "at least this many" rather than a misleading small value.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (rdy) begin
            if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (!out_valid && (bubble_cnt_q != '1)) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
            if (flush && occupied && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Elastic pipeline stage register with a valid/ready handshake on both sides.
// DEPTH=1 is a plain register (combinational ready path through the stage);
// DEPTH=2 adds a skid entry so in_ready comes straight from a flop.
// Optional feature macro: PIPE_PERF_CNT_EN adds stall/bubble/flush counters.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; 0 freezes all state
//   flush               drop all held and incoming beats this cycle
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload (NOP_WORD idle)
//   occupancy           number of held beats
//   stall_cnt, bubble_cnt, flush_cnt (PIPE_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 160,
    parameter int                DEPTH    = 2,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}},
    parameter int                CNT_W    = PIPE_CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (!pipe_depth_legal(DEPTH)) begin : g_bad_depth
        $error("pipe_stage_buf: DEPTH must be 1 or 2");
    end

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_buf: CNT_W must be at least 1");
    end

    logic              main_v_q,    main_v_d;
    logic              skid_v_q,    skid_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire;
    logic              out_fire;

    // DEPTH=1 can only accept while the held beat leaves, hence the path from
    // out_ready. DEPTH=2 always has a free slot unless the skid is in use.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && rdy) begin
            if (DEPTH == 1) begin
                in_ready = !main_v_q || out_ready;
            end else begin
                in_ready = !skid_v_q;
            end
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_v_q && out_ready && rdy;

    // Next entry state. Flush beats the handshake but the downstream transfer
    // in that cycle still happens, since out_valid was already presented.
    // Payload flops are left alone when invalidated to save toggling.
    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (rdy) begin
            if (flush) begin
                main_v_d = 1'b0;
                skid_v_d = 1'b0;
            end else if (DEPTH == 1) begin
                if (in_fire) begin
                    main_v_d    = 1'b1;
                    main_data_d = in_data;
                end else if (out_fire) begin
                    main_v_d = 1'b0;
                end
            end else if (skid_v_q) begin
                // Full: in_ready is low, so only a drain can happen.
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    skid_v_d    = 1'b0;
                end
            end else if (main_v_q) begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                end else if (in_fire) begin
                    skid_v_d    = 1'b1;
                    skid_data_d = in_data;
                end else if (out_fire) begin
                    main_v_d = 1'b0;
                end
            end else if (in_fire) begin
                main_v_d    = 1'b1;
                main_data_d = in_data;
            end
        end
    end

    // Only the valid bits see reset; payload contents of empty entries
    // are don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

    assign out_valid = main_v_q;
    assign out_data  = main_v_q ? main_data_q : NOP_WORD;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .occupied   (occupancy != 2'd0),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=1 instance share one set of
// inputs. The DEPTH=2 instance is driven from a vector table; the DEPTH=1
// combinational-ready behaviour is checked with a hand-written sequence.
module tb_pipe_stage_buf;

    localparam int          DW  = 16;
    localparam logic [15:0] NOP = 16'hBEEF;

    logic          clk = 1'b0;
    logic          rst, rdy, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          d2_in_ready, d2_out_valid;
    logic [DW-1:0] d2_out_data;
    logic [1:0]    d2_occ;
    logic          d1_in_ready, d1_out_valid;
    logic [DW-1:0] d1_out_data;
    logic [1:0]    d1_occ;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef PIPE_PERF_CNT_EN
    logic [3:0] d2_stall, d2_bubble, d2_flush;
    logic [3:0] d1_stall, d1_bubble, d1_flush;
`endif

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .NOP_WORD(NOP), .CNT_W(4)) u_d2 (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
        .occupancy(d2_occ)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(d2_stall), .bubble_cnt(d2_bubble), .flush_cnt(d2_flush)
`endif
    );

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(1), .NOP_WORD(NOP), .CNT_W(4)) u_d1 (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(d1_in_ready), .in_data(in_data),
        .out_valid(d1_out_valid), .out_ready(out_ready), .out_data(d1_out_data),
        .occupancy(d1_occ)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(d1_stall), .bubble_cnt(d1_bubble), .flush_cnt(d1_flush)
`endif
    );

    typedef struct {
        logic          rst;
        logic          rdy;
        logic          flush;
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          out_ready;
        logic          exp_in_ready;
        logic          exp_out_valid;
        logic [DW-1:0] exp_out_data;
        logic [1:0]    exp_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic y, input logic f,
                                input logic iv, input logic [DW-1:0] d,
                                input logic o, input logic eir,
                                input logic eov, input logic [DW-1:0] eod,
                                input logic [1:0] eoc);
        vec_t v;
        v.rst = r; v.rdy = y; v.flush = f; v.in_valid = iv; v.in_data = d;
        v.out_ready = o; v.exp_in_ready = eir; v.exp_out_valid = eov;
        v.exp_out_data = eod; v.exp_occ = eoc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs set just after an edge, in_ready sampled late in the cycle,
    // registered outputs sampled 1 time unit after the next edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        rst = v.rst; rdy = v.rdy; flush = v.flush; in_valid = v.in_valid;
        in_data = v.in_data; out_ready = v.out_ready;
        #3;
        checkOutput($sformatf("v%0d_in_ready", idx), 32'(d2_in_ready), 32'(v.exp_in_ready));
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_out_valid", idx), 32'(d2_out_valid), 32'(v.exp_out_valid));
        checkOutput($sformatf("v%0d_out_data", idx), 32'(d2_out_data), 32'(v.exp_out_data));
        checkOutput($sformatf("v%0d_occupancy", idx), 32'(d2_occ), 32'(v.exp_occ));
    endtask

    task automatic d1Edge(input string tag, input logic eov,
                          input logic [DW-1:0] eod, input logic [1:0] eoc);
        @(posedge clk);
        #1;
        checkOutput({tag, "_out_valid"}, 32'(d1_out_valid), 32'(eov));
        checkOutput({tag, "_out_data"}, 32'(d1_out_data), 32'(eod));
        checkOutput({tag, "_occupancy"}, 32'(d1_occ), 32'(eoc));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        vecs.push_back(mk(1, 1, 0, 0, 16'h0, 0, 0, 0, NOP, 0));
        vecs.push_back(mk(1, 1, 0, 1, 16'h7, 1, 0, 0, NOP, 0));
        // Back-to-back stream with out_ready high
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(0, 1, 0, 1, 16'(k), 1, 1, 1, 16'(k), 1));
        end
        vecs.push_back(mk(0, 1, 0, 0, 16'h0, 1, 1, 0, NOP, 0));
        // Backpressure: 0xA held, 0xB to skid, 0xC waits upstream
        vecs.push_back(mk(0, 1, 0, 1, 16'hA, 0, 1, 1, 16'hA, 1));
        vecs.push_back(mk(0, 1, 0, 1, 16'hB, 0, 1, 1, 16'hA, 2));
        vecs.push_back(mk(0, 1, 0, 1, 16'hC, 0, 0, 1, 16'hA, 2));
        vecs.push_back(mk(0, 1, 0, 1, 16'hC, 1, 0, 1, 16'hB, 1));
        vecs.push_back(mk(0, 1, 0, 1, 16'hC, 1, 1, 1, 16'hC, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0, 1, 1, 0, NOP, 0));
        // Flush with full skid and an offered 0xD
        vecs.push_back(mk(0, 1, 0, 1, 16'hA, 0, 1, 1, 16'hA, 1));
        vecs.push_back(mk(0, 1, 0, 1, 16'hB, 0, 1, 1, 16'hA, 2));
        vecs.push_back(mk(0, 1, 1, 1, 16'hD, 0, 0, 0, NOP, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0, 1, 1, 0, NOP, 0));
        // Flush while empty drops an accepted beat
        vecs.push_back(mk(0, 1, 1, 1, 16'hE, 1, 1, 0, NOP, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0, 1, 1, 0, NOP, 0));
        // rdy low for 5 cycles freezes 0x5, then it leaves exactly once
        vecs.push_back(mk(0, 1, 0, 1, 16'h5, 0, 1, 1, 16'h5, 1));
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(0, 0, 0, 1, 16'h9, 1, 0, 1, 16'h5, 1));
        end
        vecs.push_back(mk(0, 1, 0, 0, 16'h0, 1, 1, 0, NOP, 0));
        // Reset mid-stream
        vecs.push_back(mk(0, 1, 0, 1, 16'h33, 0, 1, 1, 16'h33, 1));
        vecs.push_back(mk(1, 1, 0, 1, 16'h44, 1, 0, 0, NOP, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0, 1, 1, 0, NOP, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end

        // DEPTH=1: in_ready tracks out_ready while full, nothing dropped
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        d1Edge("d1_rst", 1'b0, NOP, 2'd0);
        rst = 1'b0; in_valid = 1'b1; in_data = 16'h11; out_ready = 1'b1;
        #1 checkOutput("d1_ready_empty", 32'(d1_in_ready), 32'd1);
        d1Edge("d1_b11", 1'b1, 16'h11, 2'd1);
        in_data = 16'h22; out_ready = 1'b0;
        #1 checkOutput("d1_ready_or0", 32'(d1_in_ready), 32'd0);
        out_ready = 1'b1;
        #1 checkOutput("d1_ready_or1", 32'(d1_in_ready), 32'd1);
        out_ready = 1'b0;
        #1 checkOutput("d1_ready_or0b", 32'(d1_in_ready), 32'd0);
        d1Edge("d1_hold11", 1'b1, 16'h11, 2'd1);
        out_ready = 1'b1;
        #1 checkOutput("d1_ready_or1b", 32'(d1_in_ready), 32'd1);
        d1Edge("d1_b22", 1'b1, 16'h22, 2'd1);
        in_data = 16'h33;
        d1Edge("d1_b33", 1'b1, 16'h33, 2'd1);
        rdy = 1'b0;
        #1 checkOutput("d1_ready_rdy0", 32'(d1_in_ready), 32'd0);
        rdy = 1'b1; in_valid = 1'b0;
        d1Edge("d1_drain", 1'b0, NOP, 2'd0);

`ifdef PIPE_PERF_CNT_EN
        // Stall counter saturates at 15, reset clears all counters
        rst = 1'b1; @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b1; in_data = 16'h55; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
        end
        #1 checkOutput("perf_stall_sat", 32'(d2_stall), 32'd15);
        rst = 1'b1; @(posedge clk); #1;
        checkOutput("perf_stall_rst", 32'(d2_stall), 32'd0);
        checkOutput("perf_bubble_rst", 32'(d2_bubble), 32'd0);
        checkOutput("perf_flush_rst", 32'(d2_flush), 32'd0);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
